// File: rtl/alu_seq_if.sv
// Handshake bundle for alu_seq: operand/op input channel, result/flags output channel.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_z;
    logic             flag_n;
    logic             flag_c;
    logic             flag_v;
    logic             busy;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, busy
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with Z/N/C/V flags; single-cycle arithmetic/logic ops and
// iterative one-bit-per-clock logical shifts.
module alu_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_seq_if.slave  bus
);
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_AND  = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   diff_c;
    logic [SHW-1:0]   k_c;
    logic [WIDTH-1:0] shifted_c;
    logic             shout_c;
    logic             accept_c;
    logic             drain_c;

    // Flags packed as {Z, N, C, V}
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r,
                                            input logic c, input logic v);
        return {r == '0, r[MSB], c, v};
    endfunction

    assign bus.in_ready  = rst_n && (state_q == IDLE) && (!out_valid_q || bus.out_ready);
    assign bus.busy      = (state_q == SHIFT);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.flag_z    = flags_q[3];
    assign bus.flag_n    = flags_q[2];
    assign bus.flag_c    = flags_q[1];
    assign bus.flag_v    = flags_q[0];

    assign accept_c = bus.in_valid && bus.in_ready;
    assign drain_c  = out_valid_q && bus.out_ready;

    // Datapath helpers; extra top bit of sum/diff is carry / borrow
    always_comb begin
        sum_c     = {1'b0, bus.a} + {1'b0, bus.b};
        diff_c    = {1'b0, bus.a} - {1'b0, bus.b};
        k_c       = bus.b[SHW-1:0];
        shifted_c = dir_q ? (work_q >> 1) : (work_q << 1);
        shout_c   = dir_q ? work_q[0] : work_q[MSB];
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        dir_d       = dir_q;
        result_d    = result_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (drain_c) begin
                    out_valid_d = 1'b0;
                end
                if (accept_c) begin
                    out_valid_d = 1'b1;
                    case (bus.op)
                        OP_PASS: begin
                            result_d = bus.b;
                            flags_d  = mk_flags(bus.b, 1'b0, 1'b0);
                        end
                        OP_SUB: begin
                            result_d = diff_c[MSB:0];
                            flags_d  = mk_flags(diff_c[MSB:0], !diff_c[WIDTH],
                                                (bus.a[MSB] != bus.b[MSB]) &&
                                                (diff_c[MSB] != bus.a[MSB]));
                        end
                        OP_ADD: begin
                            result_d = sum_c[MSB:0];
                            flags_d  = mk_flags(sum_c[MSB:0], sum_c[WIDTH],
                                                (bus.a[MSB] == bus.b[MSB]) &&
                                                (sum_c[MSB] != bus.a[MSB]));
                        end
                        OP_XOR: begin
                            result_d = bus.a ^ bus.b;
                            flags_d  = mk_flags(bus.a ^ bus.b, 1'b0, 1'b0);
                        end
                        OP_OR: begin
                            result_d = bus.a | bus.b;
                            flags_d  = mk_flags(bus.a | bus.b, 1'b0, 1'b0);
                        end
                        OP_AND: begin
                            result_d = bus.a & bus.b;
                            flags_d  = mk_flags(bus.a & bus.b, 1'b0, 1'b0);
                        end
                        default: begin
                            // SHL / SHR: op[0] selects right shift
                            work_d = bus.a;
                            cnt_d  = k_c;
                            dir_d  = bus.op[0];
                            if (k_c == '0) begin
                                result_d = bus.a;
                                flags_d  = mk_flags(bus.a, 1'b0, 1'b0);
                            end else begin
                                state_d     = SHIFT;
                                out_valid_d = 1'b0;
                            end
                        end
                    endcase
                end
            end
            SHIFT: begin
                work_d = shifted_c;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d     = IDLE;
                    result_d    = shifted_c;
                    flags_d     = mk_flags(shifted_c, shout_c, 1'b0);
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            dir_q       <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            dir_q       <= dir_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed corner cases plus randomized traffic
// on a 16-bit instance, and a short run on an 8-bit instance.
module tb_alu_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    alu_seq_if #(.WIDTH(16)) if16 ();
    alu_seq_if #(.WIDTH(8))  if8 ();

    alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16.slave));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    typedef struct packed {
        logic [15:0] res;
        logic        z;
        logic        n;
        logic        c;
        logic        v;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    bit   rand_rdy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: arithmetic on plain integers, signed overflow by range test
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(a) & mask;
        longint ub   = longint'(b) & mask;
        longint sa   = (ua >= half) ? ua - (mask + 1) : ua;
        longint sb   = (ub >= half) ? ub - (mask + 1) : ub;
        int     k    = int'(ub % longint'(w));
        longint r    = 0;
        longint sr;
        logic   c    = 1'b0;
        logic   v    = 1'b0;
        case (op)
            3'd0: r = ub;
            3'd1: begin
                r = ua - ub; c = (ua >= ub);
                sr = sa - sb; v = (sr < -half) || (sr >= half);
            end
            3'd2: begin
                r = ua + ub; c = (r > mask);
                sr = sa + sb; v = (sr < -half) || (sr >= half);
            end
            3'd3: r = ua ^ ub;
            3'd4: r = ua | ub;
            3'd5: r = ua & ub;
            3'd6: begin
                r = ua << k;
                c = (k != 0) && (((ua >> (w - k)) & 1) == 1);
            end
            default: begin
                r = ua >> k;
                c = (k != 0) && (((ua >> (k - 1)) & 1) == 1);
            end
        endcase
        r     = r & mask;
        e.res = 16'(r);
        e.z   = (r == 0);
        e.n   = ((r >> (w - 1)) & 1) == 1;
        e.c   = c;
        e.v   = v;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitors: compare the head of the queue while valid, pop on transfer
    always @(negedge clk) begin
        if (rst_n && if16.out_valid) begin
            if (q16.size() == 0) begin
                checks++; errors++;
                $display("FAIL out16 unexpected output: result %h", if16.result);
            end else begin
                chk("out16", {if16.result, if16.flag_z, if16.flag_n, if16.flag_c, if16.flag_v},
                    {q16[0].res, q16[0].z, q16[0].n, q16[0].c, q16[0].v});
                if (if16.out_ready) void'(q16.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && if8.out_valid) begin
            if (q8.size() == 0) begin
                checks++; errors++;
                $display("FAIL out8 unexpected output: result %h", if8.result);
            end else begin
                chk("out8", {if8.result, if8.flag_z, if8.flag_n, if8.flag_c, if8.flag_v},
                    {q8[0].res[7:0], q8[0].z, q8[0].n, q8[0].c, q8[0].v});
                if (if8.out_ready) void'(q8.pop_front());
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge
    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bit acc;
        acc = 1'b0;
        if16.in_valid = 1'b1; if16.op = op; if16.a = a; if16.b = b;
        for (int t = 0; t < 100; t++) begin
            if (rand_rdy) if16.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = if16.in_ready;
            @(posedge clk);
            if (acc) q16.push_back(model(16, op, a, b));
            #1;
            if (acc) break;
        end
        if16.in_valid = 1'b0;
        acc_cyc = cyc;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL issue16 timeout: op %0d never accepted", op);
        end
    endtask

    task automatic issue8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        bit acc;
        acc = 1'b0;
        if8.in_valid = 1'b1; if8.op = op; if8.a = a; if8.b = b;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            acc = if8.in_ready;
            @(posedge clk);
            if (acc) q8.push_back(model(8, op, {8'h00, a}, {8'h00, b}));
            #1;
            if (acc) break;
        end
        if8.in_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL issue8 timeout: op %0d never accepted", op);
        end
    endtask

    task automatic drain16();
        if16.out_ready = 1'b1;
        for (int t = 0; t < 100 && (q16.size() != 0 || if16.out_valid); t++) step();
        chk("drain16 queue", 32'(q16.size()), 32'd0);
    endtask

    task automatic drain8();
        for (int t = 0; t < 100 && (q8.size() != 0 || if8.out_valid); t++) step();
        chk("drain8 queue", 32'(q8.size()), 32'd0);
    endtask

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [19:0] outs16();
        return {if16.result, if16.flag_z, if16.flag_n, if16.flag_c, if16.flag_v};
    endfunction

    initial begin
        if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.op = '0; if16.out_ready = 1'b1;
        if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.op  = '0; if8.out_ready  = 1'b1;

        #1 rst_n = 1'b0;
        #11;
        chk("reset in_ready", 32'(if16.in_ready), 32'd0);
        chk("reset outputs", {if16.out_valid, if16.busy, outs16()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("in_ready after reset", 32'(if16.in_ready), 32'd1);
        step();

        issue16(3'd2, 16'h7FFF, 16'h0001);
        chk("add ovf out_valid", 32'(if16.out_valid), 32'd1);
        chk("add 7fff+1", 32'(outs16()), {12'h0, 16'h8000, 4'b0101});
        issue16(3'd2, 16'hFFFF, 16'h0001);
        chk("add ffff+1", 32'(outs16()), {12'h0, 16'h0000, 4'b1010});
        issue16(3'd1, 16'h0003, 16'h0005);
        chk("sub 3-5", 32'(outs16()), {12'h0, 16'hFFFE, 4'b0100});

        issue16(3'd6, 16'h8001, 16'h0004);
        for (int i = 0; i < 4; i++) begin
            chk("shl4 busy", 32'(if16.busy), 32'd1);
            chk("shl4 in_ready", 32'(if16.in_ready), 32'd0);
            step();
        end
        chk("shl4 done", {if16.busy, if16.out_valid}, 32'b01);
        chk("shl4 result", 32'(outs16()), {12'h0, 16'h0010, 4'b0000});

        issue16(3'd7, 16'h8001, 16'h0001);
        chk("shr1 busy", 32'(if16.busy), 32'd1);
        step();
        chk("shr1 done", {if16.busy, if16.out_valid}, 32'b01);
        chk("shr1 result", 32'(outs16()), {12'h0, 16'h4000, 4'b0010});

        issue16(3'd6, 16'h1234, 16'h0010);
        chk("shift k0 single", {if16.busy, if16.out_valid}, 32'b01);
        chk("shift k0 result", 32'(outs16()), {12'h0, 16'h1234, 4'b0000});

        // Backpressure on an XOR result, then back-to-back release
        step();
        if16.out_ready = 1'b0;
        issue16(3'd3, 16'hF0F0, 16'h0FF0);
        for (int i = 0; i < 3; i++) begin
            chk("stall out_valid/in_ready", {if16.out_valid, if16.in_ready}, 32'b10);
            chk("stall xor held", 32'(outs16()), {12'h0, 16'hFF00, 4'b0100});
            step();
        end
        if16.out_ready = 1'b1;
        begin
            int c0, c1, c2;
            issue16(3'd4, 16'h1200, 16'h0034); c0 = acc_cyc;
            chk("b2b or", 32'(outs16()), {12'h0, 16'h1234, 4'b0000});
            issue16(3'd5, 16'hFF0F, 16'h0FF0); c1 = acc_cyc;
            chk("b2b and", 32'(outs16()), {12'h0, 16'h0F00, 4'b0000});
            issue16(3'd0, 16'h0000, 16'h8000); c2 = acc_cyc;
            chk("b2b pass", 32'(outs16()), {12'h0, 16'h8000, 4'b0100});
            chk("b2b spacing 1", 32'(c1 - c0), 32'd1);
            chk("b2b spacing 2", 32'(c2 - c1), 32'd1);
        end

        // Asynchronous reset in the middle of a 7-bit shift
        step();
        issue16(3'd6, 16'h00FF, 16'h0007);
        step(); step(); step();
        #2 rst_n = 1'b0;
        #1;
        chk("abort in_ready", 32'(if16.in_ready), 32'd0);
        chk("abort outputs", {if16.out_valid, if16.busy, outs16()}, 32'd0);
        q16.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("abort release in_ready", 32'(if16.in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("no stale out_valid", 32'(if16.out_valid), 32'd0);
        end

        rand_rdy = 1'b1;
        repeat (300) issue16(3'($urandom_range(0, 7)), pick16(), pick16());
        rand_rdy = 1'b0;
        drain16();

        issue8(3'd2, 8'h80, 8'h80);
        chk("w8 add 80+80", {if8.result, if8.flag_z, if8.flag_n, if8.flag_c, if8.flag_v},
            {20'h0, 8'h00, 4'b1011});
        issue8(3'd6, 8'h01, 8'h07);
        for (int i = 0; i < 7; i++) begin
            chk("w8 shl7 busy", 32'(if8.busy), 32'd1);
            step();
        end
        chk("w8 shl7 done", {if8.busy, if8.out_valid}, 32'b01);
        chk("w8 shl7 result", {if8.result, if8.flag_z, if8.flag_n, if8.flag_c, if8.flag_v},
            {20'h0, 8'h80, 4'b0100});
        repeat (60) issue8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        drain8();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the datapath's combinational 16-bit ALU. It adds a SUB operation, iterative logical shifts, and Z/N/C/V status flags. It sits between the register-file read stage and writeback. It accepts one operation per cycle over a valid/ready input and presents a registered result with flags over a valid/ready output. Shifts are multi-cycle, one bit per clock.

## Interface
- `WIDTH`, default 16: operand and result width. Must be a power of two and at least 4.
- `SHW`, default `$clog2(WIDTH)`: shift-amount width. Derived; do not override.
- `clk` input, 1 bit: the block's single clock. All state changes on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `in_valid` input, 1 bit: `a`, `b` and `op` are valid.
- `in_ready` output, 1 bit: the block can accept an operation this cycle.
- `a` input, `WIDTH` bits: operand A. This is the shifted operand for shifts.
- `b` input, `WIDTH` bits: operand B. `b[SHW-1:0]` is the shift amount.
- `op` input, 3 bits: 000 PASS_B, 001 SUB, 010 ADD, 011 XOR, 100 OR, 101 AND, 110 SHL, 111 SHR (logical).
- `out_valid` output, 1 bit: `result` and the flags are valid.
- `out_ready` input, 1 bit: the consumer takes the result this cycle.
- `result` output, `WIDTH` bits: registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v` outputs, 1 bit each: zero, negative (MSB), carry, signed overflow.
- `busy` output, 1 bit: high while a shift is iterating.

## Operation
- An input transfer happens when `in_valid && in_ready` is true at a rising edge.
- `in_ready = rst_n && !busy && (!out_valid || out_ready)`. It is combinational and must not depend on `in_valid`.
- Output transfer: `out_valid && out_ready`. While `out_valid && !out_ready`, `result` and all flags hold stable.
- If the output is drained with no new acceptance on the same edge, `out_valid` clears.
- State machine has two states:
  - IDLE: single-cycle operations complete here.
  - SHIFT: iterates shifts; `busy` = 1 in this state.
- Single-cycle ops (PASS_B, SUB, ADD, XOR, OR, AND): the result and flags are loaded on the acceptance edge, and `out_valid` is set.
- Arithmetic is modulo 2^WIDTH.
  - ADD: C is the carry out of the MSB. V is set when both operands have the same sign and the result sign differs.
  - SUB (`a - b`): C = 1 when a ≥ b unsigned (no borrow). V is set when the operand signs differ and the result sign differs from `a`.
  - PASS_B and the logic ops: C = 0, V = 0.
  - All ops: Z = (result == 0); N = result[WIDTH-1].
- Shifts (SHL, SHR), with k = `b[SHW-1:0]`:
  - Acceptance edge: the working register loads `a`, the counter loads k, and the carry register clears.
  - k = 0: stay in IDLE and complete as a single-cycle op. Result = `a`, C = 0.
  - k ≥ 1: enter SHIFT, and `out_valid` clears on the acceptance edge.
  - Each SHIFT edge: shift the working register by 1 with zero fill, capture the bit shifted out into C, and decrement the counter.
  - The edge that decrements the counter to 0 returns to IDLE. On that same edge it loads `result`/flags from the shifted value and sets `out_valid`.
  - Shifts: V = 0; Z and N come from the shifted result.
- `b` bits above `SHW-1` are ignored for shifts.
- No operation is in flight during SHIFT. Inputs are not sampled because `in_ready` = 0.

## Timing
- Reset (asynchronous assert at any time, including mid-shift):
  - State → IDLE, counter and working register → 0.
  - `result` = 0, all flags = 0, `out_valid` = 0, `busy` = 0.
  - `in_ready` = 0 while `rst_n` is low and 1 from the first cycle after deassertion.
  - An aborted shift produces no output.
- Single-cycle op accepted at edge E: `out_valid` = 1 from E. Latency is 1 cycle.
- Throughput is 1 op per cycle when `out_ready` is held high.
- Shift by k ≥ 1 accepted at edge E: `busy` = 1 from E through E+k-1, and `busy` = 0 with `out_valid` = 1 from E+k.
- `in_ready` is low from E through E+k-1 and can be high again in the cycle after E+k-1.
- Simultaneous drain and accept on the same edge: the new result replaces the old one and `out_valid` stays 1, with no bubble. If the accepted op is a shift with k ≥ 1, `out_valid` goes to 0.

## Test plan
- Reset, then ADD with `a`=0x7FFF, `b`=0x0001 → `result`=0x8000, N=1, V=1, C=0, Z=0, with `out_valid` one cycle after accept.
- ADD with 0xFFFF + 0x0001 → `result`=0x0000, Z=1, C=1, V=0. Then SUB with 0x0003 − 0x0005 → `result`=0xFFFE, C=0, N=1, V=0.
- SHL with `a`=0x8001, `b`=0x0004 → `busy` high for 4 cycles, `in_ready` low, then `result`=0x0010, C=0. SHR with `a`=0x8001, `b`=1 → `result`=0x4000, C=1, after 1 cycle of `busy`. Shift with k=0 (`b`=0x0010) → `result`=`a`, single cycle.
- Hold `out_ready`=0 for 3 cycles after an XOR result → `result`/flags stable and `in_ready`=0. Raise `out_ready` with `in_valid` high on OR/AND/PASS_B back-to-back → one result per cycle, with correct values in order.
- Assert `rst_n` low mid-way through a SHL by 7 → all outputs are 0 immediately. After release, `in_ready`=1 and no stale `out_valid` appears.
- With `WIDTH`=8: ADD 0x80 + 0x80 → `result`=0x00, C=1, V=1, Z=1. SHL with `a`=0x01, `b`=0x07 → `result`=0x80, N=1, after 7 busy cycles.
